lcd_power_sequencer: RTL and testbench

Panel power-sequencing controller for the LCD driver. Drives the panel supply enable, the HV timing generator enable, the display-on line and the backlight enable in the order the panel datasheet requires. Counts clock cycles for supply settling and counts frames, from the timing generator's `vsync`, for the display and backlight steps. Sits between the host's `power_on` request and the HV timing generator's `en` input.

---
 rtl/lcd_power_sequencer.sv | 176 +++++++++++++++++
 tb/tb_lcd_power_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_power_sequencer.sv
// LCD panel power sequencer: orders panel supply, timing generator, DISP and backlight.
// Define LCD_SEQ_WDOG_EN to add the missing-vsync watchdog and the sticky fault flag.
module lcd_power_sequencer #(
    parameter int unsigned T_PWR_ON     = 20000,
    parameter int unsigned T_PWR_OFF    = 20000,
    parameter int unsigned N_FRAMES_ON  = 10,
    parameter int unsigned N_FRAMES_BL  = 2,
    parameter int unsigned N_FRAMES_OFF = 2,
`ifdef LCD_SEQ_WDOG_EN
    parameter int unsigned WDOG_CYCLES  = 2000000,
`endif
    parameter int unsigned CNT_W        = 24
) (
    input  logic       clock,
    input  logic       reset_L,
    input  logic       power_on,
    input  logic       vsync,
    output logic       vdd_en,
    output logic       timing_en,
    output logic       disp_on,
    output logic       bl_en,
    output logic       busy,
    output logic [2:0] state,
    output logic       fault
);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_PWR_UP    = 3'd1,
        ST_SYNC_UP   = 3'd2,
        ST_DISP_UP   = 3'd3,
        ST_ON        = 3'd4,
        ST_BL_DOWN   = 3'd5,
        ST_DISP_DOWN = 3'd6,
        ST_PWR_DOWN  = 3'd7
    } state_t;

    state_t             cur_state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               vsync_q;
    logic               tick;
    logic               frame_st;
    logic               wdog_trip;
    logic               vdd_c;
    logic               timing_c;
    logic               disp_c;
    logic               bl_c;
    logic               busy_c;

    assign tick     = vsync & ~vsync_q;
    assign frame_st = (cur_state == ST_SYNC_UP)  || (cur_state == ST_DISP_UP) ||
                      (cur_state == ST_BL_DOWN)  || (cur_state == ST_DISP_DOWN);
    assign state    = cur_state;

    // State register, shared step counter and vsync history
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            cur_state <= ST_OFF;
            cnt       <= '0;
            vsync_q   <= 1'b0;
        end else begin
            cur_state <= state_nxt;
            cnt       <= cnt_nxt;
            vsync_q   <= vsync;
        end
    end

    // Next-state: aborts are checked before completions; watchdog overrides both
    always_comb begin
        state_nxt = cur_state;
        cnt_nxt   = cnt;
        case (cur_state)
            ST_OFF: begin
                if (power_on && !fault) state_nxt = ST_PWR_UP;
            end
            ST_PWR_UP: begin
                if (!power_on)                              state_nxt = ST_PWR_DOWN;
                else if (cnt == CNT_W'(T_PWR_ON - 1))       state_nxt = ST_SYNC_UP;
            end
            ST_SYNC_UP: begin
                if (!power_on)                                      state_nxt = ST_PWR_DOWN;
                else if (tick && (cnt == CNT_W'(N_FRAMES_ON - 1)))  state_nxt = ST_DISP_UP;
            end
            ST_DISP_UP: begin
                if (!power_on)                                      state_nxt = ST_DISP_DOWN;
                else if (tick && (cnt == CNT_W'(N_FRAMES_BL - 1)))  state_nxt = ST_ON;
            end
            ST_ON: begin
                if (!power_on) state_nxt = ST_BL_DOWN;
            end
            ST_BL_DOWN: begin
                if (tick && (cnt == CNT_W'(N_FRAMES_OFF - 1))) state_nxt = ST_DISP_DOWN;
            end
            ST_DISP_DOWN: begin
                if (tick && (cnt == CNT_W'(N_FRAMES_OFF - 1))) state_nxt = ST_PWR_DOWN;
            end
            ST_PWR_DOWN: begin
                if (cnt == CNT_W'(T_PWR_OFF - 1)) state_nxt = ST_OFF;
            end
            default: state_nxt = ST_OFF;
        endcase
        if (wdog_trip) state_nxt = ST_PWR_DOWN;

        if (state_nxt != cur_state)
            cnt_nxt = '0;
        else if ((cur_state == ST_PWR_UP) || (cur_state == ST_PWR_DOWN))
            cnt_nxt = cnt + CNT_W'(1);
        else if (frame_st && tick)
            cnt_nxt = cnt + CNT_W'(1);
    end

    // Output decode of the upcoming state so the registered outputs track the state register
    always_comb begin
        vdd_c    = (state_nxt != ST_OFF);
        timing_c = (state_nxt == ST_SYNC_UP) || (state_nxt == ST_DISP_UP) ||
                   (state_nxt == ST_ON)      || (state_nxt == ST_BL_DOWN) ||
                   (state_nxt == ST_DISP_DOWN);
        disp_c   = (state_nxt == ST_DISP_UP) || (state_nxt == ST_ON) ||
                   (state_nxt == ST_BL_DOWN);
        bl_c     = (state_nxt == ST_ON);
        busy_c   = (state_nxt != ST_OFF) && (state_nxt != ST_ON);
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            vdd_en    <= 1'b0;
            timing_en <= 1'b0;
            disp_on   <= 1'b0;
            bl_en     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            vdd_en    <= vdd_c;
            timing_en <= timing_c;
            disp_on   <= disp_c;
            bl_en     <= bl_c;
            busy      <= busy_c;
        end
    end

`ifdef LCD_SEQ_WDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_cnt_nxt;
    logic            fault_nxt;

    // Clocks since the last frame tick; trips after WDOG_CYCLES tickless clocks
    assign wdog_trip = frame_st && !tick && (wd_cnt == WD_W'(WDOG_CYCLES - 1));

    always_comb begin
        wd_cnt_nxt = wd_cnt + WD_W'(1);
        if (!frame_st || tick || (state_nxt != cur_state)) wd_cnt_nxt = '0;
        fault_nxt = fault;
        if (wdog_trip)
            fault_nxt = 1'b1;
        else if ((state_nxt == ST_OFF) && !power_on)
            fault_nxt = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            wd_cnt <= '0;
            fault  <= 1'b0;
        end else begin
            wd_cnt <= wd_cnt_nxt;
            fault  <= fault_nxt;
        end
    end
`else
    assign wdog_trip = 1'b0;
    assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_power_sequencer.sv
// Scoreboard bench for lcd_power_sequencer: stimulus queues timed output snapshots,
// a negedge monitor pops one each time the outputs change.
module tb_lcd_power_sequencer;

    localparam logic [2:0] S_OFF       = 3'd0;
    localparam logic [2:0] S_PWR_UP    = 3'd1;
    localparam logic [2:0] S_SYNC_UP   = 3'd2;
    localparam logic [2:0] S_DISP_UP   = 3'd3;
    localparam logic [2:0] S_ON        = 3'd4;
    localparam logic [2:0] S_BL_DOWN   = 3'd5;
    localparam logic [2:0] S_DISP_DOWN = 3'd6;
    localparam logic [2:0] S_PWR_DOWN  = 3'd7;

    // {vdd_en, timing_en, disp_on, bl_en, busy}
    localparam logic [4:0] O_OFF  = 5'b00000;
    localparam logic [4:0] O_VDD  = 5'b10001;
    localparam logic [4:0] O_TIM  = 5'b11001;
    localparam logic [4:0] O_DISP = 5'b11101;
    localparam logic [4:0] O_ON   = 5'b11110;

    logic       clock    = 1'b0;
    logic       reset_L  = 1'b1;
    logic       power_on = 1'b0;
    logic       vsync    = 1'b0;
    logic       vdd_en, timing_en, disp_on, bl_en, busy, fault;
    logic [2:0] state;

    lcd_power_sequencer #(
        .T_PWR_ON     (8),
        .T_PWR_OFF    (8),
        .N_FRAMES_ON  (3),
        .N_FRAMES_BL  (2),
        .N_FRAMES_OFF (2),
`ifdef LCD_SEQ_WDOG_EN
        .WDOG_CYCLES  (100),
`endif
        .CNT_W        (24)
    ) dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .power_on  (power_on),
        .vsync     (vsync),
        .vdd_en    (vdd_en),
        .timing_en (timing_en),
        .disp_on   (disp_on),
        .bl_en     (bl_en),
        .busy      (busy),
        .state     (state),
        .fault     (fault)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [8:0] snap;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         n_cmp   = 0;
    int         n_fail  = 0;
    logic [8:0] prev    = 9'b0;
    logic [8:0] s;
    logic       chk_req = 1'b0;
    logic       done    = 1'b0;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input int dc, input logic [2:0] st, input logic [4:0] o,
                        input logic f, input string name);
        exp_t x;
        x.cyc  = cyc + dc;
        x.snap = {f, st, o};
        x.name = name;
        exp_q.push_back(x);
    endtask

    // One 50-clock frame; the tick it produces is seen on the posedge that ends the frame
    task automatic frame();
        step(49);
        vsync = 1'b1;
        step(1);
        vsync = 1'b0;
    endtask

    task automatic frames_to_on(input string tag);
        frame();
        frame();
        push(50, S_DISP_UP, O_DISP, 1'b0, {tag, "_disp_up"});
        frame();
        frame();
        push(50, S_ON, O_ON, 1'b0, {tag, "_on"});
        frame();
    endtask

    // Monitor: compare on every output change, or when stimulus forces a sample
    always @(negedge clock) begin
        s = {fault, state, vdd_en, timing_en, disp_on, bl_en, busy};
        if (done) begin
            n_cmp++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL pending_events: got %0d left, required 0", exp_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
        end else if ((s !== prev) || chk_req) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change: got cyc=%0d snap=%b, required no change", cyc, s);
            end else begin
                e = exp_q.pop_front();
                if ((e.cyc != cyc) || (e.snap !== s)) begin
                    n_fail++;
                    $display("FAIL %s: got cyc=%0d snap=%b, required cyc=%0d snap=%b",
                             e.name, cyc, s, e.cyc, e.snap);
                end
            end
            prev = s;
        end
    end

    initial begin
        #1 reset_L = 1'b0;
        step(2);
        push(0, S_OFF, O_OFF, 1'b0, "reset_state");
        chk_req = 1'b1;
        step(1);
        chk_req = 1'b0;
        reset_L = 1'b1;
        step(3);

        // Full power-up; a vsync pulse during PWR_UP must not shorten it
        power_on = 1'b1;
        push(1, S_PWR_UP,  O_VDD, 1'b0, "up_pwr_up");
        push(9, S_SYNC_UP, O_TIM, 1'b0, "up_sync_up");
        step(3);
        vsync = 1'b1;
        step(1);
        vsync = 1'b0;
        step(5);
        frames_to_on("up");
        step(5);

        // Ordered power-down from ON
        power_on = 1'b0;
        push(1, S_BL_DOWN, O_DISP, 1'b0, "down_bl_down");
        step(1);
        frame();
        push(50, S_DISP_DOWN, O_TIM, 1'b0, "down_disp_down");
        frame();
        frame();
        push(50, S_PWR_DOWN, O_VDD, 1'b0, "down_pwr_down");
        frame();
        push(8, S_OFF, O_OFF, 1'b0, "down_off");
        step(12);

        // Abort at PWR_UP count 3
        power_on = 1'b1;
        push(1,  S_PWR_UP,   O_VDD, 1'b0, "abort_pwr_up");
        push(5,  S_PWR_DOWN, O_VDD, 1'b0, "abort_pwr_down");
        push(13, S_OFF,      O_OFF, 1'b0, "abort_off");
        step(4);
        power_on = 1'b0;
        step(15);

        // Abort on the completing tick of DISP_UP, then reassert during DISP_DOWN
        power_on = 1'b1;
        push(1, S_PWR_UP,  O_VDD, 1'b0, "ign_pwr_up");
        push(9, S_SYNC_UP, O_TIM, 1'b0, "ign_sync_up");
        step(9);
        frame();
        frame();
        push(50, S_DISP_UP, O_DISP, 1'b0, "ign_disp_up");
        frame();
        frame();
        step(49);
        vsync    = 1'b1;
        power_on = 1'b0;
        push(1, S_DISP_DOWN, O_TIM, 1'b0, "abort_beats_tick");
        step(1);
        vsync = 1'b0;
        step(5);
        power_on = 1'b1;
        frame();
        push(50, S_PWR_DOWN, O_VDD, 1'b0, "ign_pwr_down");
        frame();
        push(8,  S_OFF,      O_OFF, 1'b0, "ign_off");
        push(9,  S_PWR_UP,   O_VDD, 1'b0, "restart_pwr_up");
        push(17, S_SYNC_UP,  O_TIM, 1'b0, "restart_sync_up");
        step(17);
        frames_to_on("restart");
        step(3);

        // Asynchronous reset while ON
        push(0, S_OFF, O_OFF, 1'b0, "reset_in_on");
        reset_L = 1'b0;
        step(2);
        power_on = 1'b0;
        reset_L  = 1'b1;
        step(3);

`ifdef LCD_SEQ_WDOG_EN
        // Watchdog: no vsync in SYNC_UP
        power_on = 1'b1;
        push(1,   S_PWR_UP,   O_VDD, 1'b0, "wd_pwr_up");
        push(9,   S_SYNC_UP,  O_TIM, 1'b0, "wd_sync_up");
        push(109, S_PWR_DOWN, O_VDD, 1'b1, "wd_trip");
        push(117, S_OFF,      O_OFF, 1'b1, "wd_off_held");
        step(130);
        power_on = 1'b0;
        push(1, S_OFF, O_OFF, 1'b0, "wd_fault_clear");
        step(5);
`endif

        step(20);
        done = 1'b1;
        step(3);
        $display("FAIL summary_not_reached");
        $fatal(1);
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule
